// File: rtl/pacman_motion.sv
// Per-frame Pac-Man sprite mover: latches the wanted direction from the keycode,
// resolves walls through a req/ack tile query, then steps the sprite. Option: PACMAN_TUNNEL_EN.
module pacman_motion #(
  parameter int          TILE_LOG2 = 3,
  parameter int          MAZE_W    = 28,
  parameter int          MAZE_H    = 31,
  parameter logic [9:0]  START_X   = 10'd104,
  parameter logic [9:0]  START_Y   = 10'd184,
  parameter int          STEP      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic       wall_req,
  output logic [5:0] wall_tile_x,
  output logic [5:0] wall_tile_y,
  input  logic       wall_ack,
  input  logic       wall_is_wall,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       moving
);

  localparam logic [5:0] LAST_TX = 6'(MAZE_W - 1);
  localparam logic [5:0] LAST_TY = 6'(MAZE_H - 1);
  localparam logic [9:0] MAX_X   = 10'((MAZE_W - 1) << TILE_LOG2);
  localparam logic [9:0] MAX_Y   = 10'((MAZE_H - 1) << TILE_LOG2);
  localparam logic [9:0] STEP_V  = 10'(STEP);

  typedef enum logic [2:0] {IDLE, DECIDE, Q_WANT, Q_CUR, MOVE} state_t;

  state_t      state, state_nxt;
  logic        vs_d, tick;
  logic [1:0]  want, key_dir, query_dir, dir_val, issue_dir;
  logic        want_valid, key_hit;
  logic        aligned;
  logic [5:0]  cur_tx, cur_ty;
  logic [12:0] tgt_want, tgt_cur;
  logic [11:0] issue_tile;
  logic        issue, drop_req, dir_load, stop, step_en;
  logic        move_blk;
  logic [9:0]  next_x, next_y;

  // Neighbour tile {blocked, x, y}; blocked means an edge that never needs a query.
  function automatic logic [12:0] target(input logic [1:0] d, input logic [5:0] tx,
                                         input logic [5:0] ty);
    logic       blk;
    logic [5:0] nx, ny;
    blk = 1'b0;
    nx  = tx;
    ny  = ty;
    case (d)
      2'b00: begin
        if (tx == LAST_TX) begin
`ifdef PACMAN_TUNNEL_EN
          nx = 6'd0;
`else
          blk = 1'b1;
`endif
        end else begin
          nx = tx + 6'd1;
        end
      end
      2'b01: begin
        if (ty == 6'd0) blk = 1'b1;
        else            ny = ty - 6'd1;
      end
      2'b10: begin
        if (tx == 6'd0) begin
`ifdef PACMAN_TUNNEL_EN
          nx = LAST_TX;
`else
          blk = 1'b1;
`endif
        end else begin
          nx = tx - 6'd1;
        end
      end
      default: begin
        if (ty == LAST_TY) blk = 1'b1;
        else               ny = ty + 6'd1;
      end
    endcase
    return {blk, nx, ny};
  endfunction

  assign tick     = vs_d & ~vs;
  assign aligned  = (pos_x[TILE_LOG2-1:0] == '0) && (pos_y[TILE_LOG2-1:0] == '0);
  assign cur_tx   = 6'(pos_x >> TILE_LOG2);
  assign cur_ty   = 6'(pos_y >> TILE_LOG2);
  assign tgt_want = target(want, cur_tx, cur_ty);
  assign tgt_cur  = target(dir, cur_tx, cur_ty);

  always_comb begin
    key_hit = 1'b1;
    key_dir = 2'b00;
    case (keycode)
      8'h07:   key_dir = 2'b00;
      8'h1A:   key_dir = 2'b01;
      8'h04:   key_dir = 2'b10;
      8'h16:   key_dir = 2'b11;
      default: key_hit = 1'b0;
    endcase
  end

  // One pixel step in dir; edges either wrap (tunnel) or block, checked before subtracting.
  always_comb begin
    move_blk = 1'b0;
    next_x   = pos_x;
    next_y   = pos_y;
    case (dir)
      2'b00: begin
        if (pos_x >= MAX_X) begin
`ifdef PACMAN_TUNNEL_EN
          next_x = 10'd0;
`else
          move_blk = 1'b1;
`endif
        end else begin
          next_x = pos_x + STEP_V;
        end
      end
      2'b01: begin
        if (pos_y < STEP_V) move_blk = 1'b1;
        else                next_y   = pos_y - STEP_V;
      end
      2'b10: begin
        if (pos_x < STEP_V) begin
`ifdef PACMAN_TUNNEL_EN
          next_x = MAX_X;
`else
          move_blk = 1'b1;
`endif
        end else begin
          next_x = pos_x - STEP_V;
        end
      end
      default: begin
        if (pos_y >= MAX_Y) move_blk = 1'b1;
        else                next_y   = pos_y + STEP_V;
      end
    endcase
  end

  // Query handshake: wall_req rises in the cycle after a Q_* state issues the tile and
  // holds with a stable tile until wall_ack is sampled high; it drops the next cycle.
  // wall_is_wall is only looked at together with wall_ack; acks with wall_req low are ignored.
  always_comb begin
    state_nxt  = state;
    dir_load   = 1'b0;
    dir_val    = dir;
    issue      = 1'b0;
    issue_tile = tgt_cur[11:0];
    issue_dir  = dir;
    drop_req   = 1'b0;
    stop       = 1'b0;
    step_en    = 1'b0;
    case (state)
      IDLE: if (tick) state_nxt = DECIDE;
      DECIDE: begin
        if (want_valid && (want == (dir ^ 2'b10))) begin
          dir_load  = 1'b1;
          dir_val   = want;
          state_nxt = MOVE;
        end else if (aligned && want_valid && (want != dir)) begin
          state_nxt = Q_WANT;
        end else if (aligned) begin
          state_nxt = Q_CUR;
        end else begin
          state_nxt = MOVE;
        end
      end
      Q_WANT: begin
        if (!wall_req) begin
          if (tgt_want[12]) begin
            state_nxt = Q_CUR;
          end else begin
            issue      = 1'b1;
            issue_tile = tgt_want[11:0];
            issue_dir  = want;
          end
        end else if (wall_ack) begin
          drop_req = 1'b1;
          if (!wall_is_wall) begin
            dir_load  = 1'b1;
            dir_val   = query_dir;
            state_nxt = MOVE;
          end else begin
            state_nxt = Q_CUR;
          end
        end
      end
      Q_CUR: begin
        if (!wall_req) begin
          if (tgt_cur[12]) begin
            stop      = 1'b1;
            state_nxt = IDLE;
          end else begin
            issue = 1'b1;
          end
        end else if (wall_ack) begin
          drop_req = 1'b1;
          if (wall_is_wall) begin
            stop      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = MOVE;
          end
        end
      end
      MOVE: begin
        step_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d        <= 1'b0;
      want        <= 2'b00;
      want_valid  <= 1'b0;
      query_dir   <= 2'b00;
      pos_x       <= START_X;
      pos_y       <= START_Y;
      dir         <= 2'b10;
      moving      <= 1'b0;
      wall_req    <= 1'b0;
      wall_tile_x <= 6'd0;
      wall_tile_y <= 6'd0;
    end else begin
      vs_d <= vs;
      if (key_hit) begin
        want       <= key_dir;
        want_valid <= 1'b1;
      end
      if (issue) begin
        wall_req    <= 1'b1;
        wall_tile_x <= issue_tile[11:6];
        wall_tile_y <= issue_tile[5:0];
        query_dir   <= issue_dir;
      end else if (drop_req) begin
        wall_req <= 1'b0;
      end
      if (dir_load) dir <= dir_val;
      if (stop) moving <= 1'b0;
      if (step_en) begin
        if (move_blk) begin
          moving <= 1'b0;
        end else begin
          pos_x  <= next_x;
          pos_y  <= next_y;
          moving <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: frame-by-frame sprite moves with a delayed wall responder.
module tb_pacman_motion;

  logic       clk = 1'b0;
  logic       reset, vs, wall_ack, wall_is_wall, wall_req, moving;
  logic [7:0] keycode;
  logic [5:0] wall_tile_x, wall_tile_y;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir;

  int checks   = 0;
  int failures = 0;
  int ack_delay = 2;
  int wall_mode = 0;               // 0 all open, 1 all wall, 2 wall only at (wall_tx, wall_ty)
  logic [5:0] wall_tx = 6'd0;
  logic [5:0] wall_ty = 6'd0;
  int req_count = 0;
  logic [11:0] req_log[$];
  logic [11:0] exp_q[$];

  pacman_motion dut (
    .clk(clk), .reset(reset), .vs(vs), .keycode(keycode),
    .wall_req(wall_req), .wall_tile_x(wall_tile_x), .wall_tile_y(wall_tile_y),
    .wall_ack(wall_ack), .wall_is_wall(wall_is_wall),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving)
  );

  always #5 clk = ~clk;

  // Tile store model: answers each request after ack_delay cycles with a one-cycle ack.
  initial begin
    logic [5:0] qx, qy;
    wall_ack = 1'b0;
    wall_is_wall = 1'b0;
    forever begin
      @(negedge clk);
      if (wall_req === 1'b1) begin
        qx = wall_tile_x;
        qy = wall_tile_y;
        req_count++;
        req_log.push_back({qx, qy});
        repeat (ack_delay - 1) @(negedge clk);
        wall_ack = 1'b1;
        wall_is_wall = (wall_mode == 1) || ((wall_mode == 2) && (qx == wall_tx) && (qy == wall_ty));
        @(negedge clk);
        wall_ack = 1'b0;
        wall_is_wall = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; keycode = 8'h00; vs = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame();
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    @(negedge clk);
    keycode = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pos_x !== 10'd104) begin failures++; $display("FAIL reset_pos_x: got %0d expected 104", pos_x); end
    checks++; if (pos_y !== 10'd184) begin failures++; $display("FAIL reset_pos_y: got %0d expected 184", pos_y); end
    checks++; if (dir !== 2'b10) begin failures++; $display("FAIL reset_dir: got %b expected 10", dir); end
    checks++; if (moving !== 1'b0) begin failures++; $display("FAIL reset_moving: got %b expected 0", moving); end
    checks++; if (wall_req !== 1'b0) begin failures++; $display("FAIL reset_wall_req: got %b expected 0", wall_req); end
    checks++; if ({wall_tile_x, wall_tile_y} !== 12'd0) begin failures++; $display("FAIL reset_tile: got (%0d,%0d) expected (0,0)", wall_tile_x, wall_tile_y); end
  endtask

  task automatic test_straight_left();
    ack_delay = 2; wall_mode = 0; req_count = 0; req_log.delete();
    repeat (3) frame();
    checks++; if (pos_x !== 10'd101) begin failures++; $display("FAIL left_pos_x: got %0d expected 101", pos_x); end
    checks++; if (pos_y !== 10'd184) begin failures++; $display("FAIL left_pos_y: got %0d expected 184", pos_y); end
    checks++; if (dir !== 2'b10) begin failures++; $display("FAIL left_dir: got %b expected 10", dir); end
    checks++; if (moving !== 1'b1) begin failures++; $display("FAIL left_moving: got %b expected 1", moving); end
    checks++; if (req_count != 1) begin failures++; $display("FAIL left_req_count: got %0d expected 1", req_count); end
    checks++; if (req_log.size() == 0 || req_log[0] !== {6'd12, 6'd23}) begin failures++; $display("FAIL left_query_tile: got size %0d first %h expected %h", req_log.size(), (req_log.size() > 0) ? req_log[0] : 12'hfff, {6'd12, 6'd23}); end
  endtask

  task automatic test_reverse_unaligned();
    req_count = 0;
    press(8'h07);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    checks++; if (pos_x !== 10'd101) begin failures++; $display("FAIL rev_early: got %0d expected 101", pos_x); end
    @(negedge clk);
    checks++; if (pos_x !== 10'd102) begin failures++; $display("FAIL rev_pos_x: got %0d expected 102", pos_x); end
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL rev_dir: got %b expected 00", dir); end
    repeat (10) @(negedge clk);
    checks++; if (req_count != 0) begin failures++; $display("FAIL rev_no_query: got %0d requests expected 0", req_count); end
  endtask

  task automatic test_want_blocked();
    do_reset();
    ack_delay = 2; wall_mode = 2; wall_tx = 6'd13; wall_ty = 6'd22; req_count = 0; req_log.delete();
    press(8'h1A);
    frame();
    exp_q.delete();
    exp_q.push_back({6'd13, 6'd22});
    exp_q.push_back({6'd12, 6'd23});
    checks++; if (req_log.size() != exp_q.size()) begin failures++; $display("FAIL want_query_count: got %0d expected %0d", req_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
      checks++; if (req_log[i] !== exp_q[i]) begin failures++; $display("FAIL want_query_tile[%0d]: got %h expected %h", i, req_log[i], exp_q[i]); end
    end
    checks++; if (dir !== 2'b10) begin failures++; $display("FAIL want_dir: got %b expected 10", dir); end
    checks++; if (pos_x !== 10'd103) begin failures++; $display("FAIL want_pos_x: got %0d expected 103", pos_x); end
    repeat (7) frame();
    checks++; if (pos_x !== 10'd96) begin failures++; $display("FAIL want_walk_pos_x: got %0d expected 96", pos_x); end
    req_log.delete();
    frame();
    checks++; if (req_log.size() == 0 || req_log[0] !== {6'd12, 6'd22}) begin failures++; $display("FAIL want_kept_query: got size %0d expected first %h", req_log.size(), {6'd12, 6'd22}); end
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL want_turn_dir: got %b expected 01", dir); end
    checks++; if (pos_y !== 10'd183 || pos_x !== 10'd96) begin failures++; $display("FAIL want_turn_pos: got (%0d,%0d) expected (96,183)", pos_x, pos_y); end
  endtask

  task automatic test_wall_stop();
    do_reset();
    ack_delay = 2; wall_mode = 0;
    press(8'h07);
    repeat (8) frame();
    checks++; if (pos_x !== 10'd112 || dir !== 2'b00) begin failures++; $display("FAIL stop_setup: got x=%0d dir=%b expected x=112 dir=00", pos_x, dir); end
    wall_mode = 1; req_count = 0; req_log.delete();
    repeat (2) frame();
    checks++; if (pos_x !== 10'd112) begin failures++; $display("FAIL stop_pos_x: got %0d expected 112", pos_x); end
    checks++; if (moving !== 1'b0) begin failures++; $display("FAIL stop_moving: got %b expected 0", moving); end
    checks++; if (req_count != 2) begin failures++; $display("FAIL stop_req_count: got %0d expected 2", req_count); end
    checks++; if (req_log.size() == 0 || req_log[0] !== {6'd15, 6'd23}) begin failures++; $display("FAIL stop_query_tile: got size %0d expected first %h", req_log.size(), {6'd15, 6'd23}); end
  endtask

  task automatic test_left_edge();
    do_reset();
    ack_delay = 2; wall_mode = 0;
    repeat (104) frame();
    checks++; if (pos_x !== 10'd0 || moving !== 1'b1) begin failures++; $display("FAIL edge_setup: got x=%0d moving=%b expected x=0 moving=1", pos_x, moving); end
    req_count = 0; req_log.delete();
    frame();
`ifdef PACMAN_TUNNEL_EN
    checks++; if (pos_x !== 10'd216) begin failures++; $display("FAIL edge_wrap_x: got %0d expected 216", pos_x); end
    checks++; if (req_log.size() == 0 || req_log[0] !== {6'd27, 6'd23}) begin failures++; $display("FAIL edge_wrap_query: got size %0d expected first %h", req_log.size(), {6'd27, 6'd23}); end
    checks++; if (moving !== 1'b1) begin failures++; $display("FAIL edge_wrap_moving: got %b expected 1", moving); end
`else
    checks++; if (pos_x !== 10'd0) begin failures++; $display("FAIL edge_block_x: got %0d expected 0", pos_x); end
    checks++; if (req_count != 0) begin failures++; $display("FAIL edge_no_query: got %0d expected 0", req_count); end
    checks++; if (moving !== 1'b0) begin failures++; $display("FAIL edge_block_moving: got %b expected 0", moving); end
`endif
  endtask

  task automatic test_reset_mid_query();
    int n;
    do_reset();
    ack_delay = 10; wall_mode = 0; req_count = 0;
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    n = 0;
    while (wall_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (wall_req !== 1'b1) begin failures++; $display("FAIL slow_req_timeout: wall_req=%b expected 1", wall_req); end
    @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (pos_x !== 10'd103) begin failures++; $display("FAIL drop_tick_pos_x: got %0d expected 103", pos_x); end
    checks++; if (req_count != 1) begin failures++; $display("FAIL drop_tick_reqs: got %0d expected 1", req_count); end

    do_reset();
    req_count = 0;
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    n = 0;
    while (wall_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (wall_req !== 1'b1) begin failures++; $display("FAIL midq_req_timeout: wall_req=%b expected 1", wall_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (wall_req !== 1'b0) begin failures++; $display("FAIL midq_req_drop: got %b expected 0", wall_req); end
    checks++; if ({wall_tile_x, wall_tile_y} !== 12'd0) begin failures++; $display("FAIL midq_tile: got (%0d,%0d) expected (0,0)", wall_tile_x, wall_tile_y); end
    checks++; if (pos_x !== 10'd104 || pos_y !== 10'd184 || dir !== 2'b10 || moving !== 1'b0) begin failures++; $display("FAIL midq_outputs: got (%0d,%0d) dir=%b moving=%b expected (104,184) dir=10 moving=0", pos_x, pos_y, dir, moving); end
    repeat (15) @(negedge clk);
    checks++; if (wall_req !== 1'b0 || pos_x !== 10'd104 || moving !== 1'b0) begin failures++; $display("FAIL late_ack: got req=%b x=%0d moving=%b expected req=0 x=104 moving=0", wall_req, pos_x, moving); end
    checks++; if (req_count != 1) begin failures++; $display("FAIL late_ack_reqs: got %0d expected 1", req_count); end
  endtask

  initial begin
    reset = 1'b1; vs = 1'b1; keycode = 8'h00;
    test_reset();
    test_straight_left();
    test_reverse_unaligned();
    test_want_blocked();
    test_wall_stop();
    test_left_edge();
    test_reset_mid_query();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pacman_motion.md
Name: pacman_motion

Overview:
- Moves the Pac-Man sprite once per video frame and holds its position for the colour mapper.
- Sits between the SoC keycode export and the colour mapper. It takes the 8-bit USB HID keycode and the vertical-sync output of the VGA controller.
- It produces the sprite pixel position, direction and a moving flag.
- Wall collisions are resolved through a req/ack query port to the maze tile store.

Parameters:
- TILE_LOG2, 3: tile size in pixels is 2**TILE_LOG2 (8 px).
- MAZE_W, 28: maze width in tiles.
- MAZE_H, 31: maze height in tiles.
- START_X, 10'd104: reset pixel x. Must be tile-aligned.
- START_Y, 10'd184: reset pixel y. Must be tile-aligned.
- STEP, 1: pixels moved per frame. Must divide 2**TILE_LOG2.

Ports:
- clk  in  1  system clock (MAX10_CLK1_50 domain)
- reset  in  1  synchronous, active-high
- vs  in  1  VGA vertical sync, active low
- keycode  in  8  USB HID keycode from the SoC
- wall_req  out  1  wall query request
- wall_tile_x  out  6  queried tile column
- wall_tile_y  out  6  queried tile row
- wall_ack  in  1  query answered (single-cycle pulse)
- wall_is_wall  in  1  query result; valid only when wall_ack=1
- pos_x  out  10  sprite top-left x in pixels
- pos_y  out  10  sprite top-left y in pixels
- dir  out  2  current direction: 00 right, 01 up, 10 left, 11 down
- moving  out  1  sprite advanced on the last frame

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - pos_x=START_X, pos_y=START_Y, dir=2'b10, moving=0.
  - wall_req=0, wall_tile_x=0, wall_tile_y=0.
  - want_valid=0, state=IDLE, vs_d=0.
- Reset mid-query drops wall_req on the next clock and ignores any later ack.
- Frame tick: vs_d registers vs. tick = vs_d & ~vs (falling edge).
  - A tick seen in any state other than IDLE is dropped (frame skipped).
- Wanted-direction latch, checked every cycle:
  - keycode 0x07 (D) → want=00; 0x1A (W) → 01; 0x04 (A) → 10; 0x16 (S) → 11.
  - On a match, want_valid=1.
  - Any other keycode, including 0x00, leaves want unchanged.
- aligned = (pos_x[TILE_LOG2-1:0]==0) && (pos_y[TILE_LOG2-1:0]==0).
- The target tile is the neighbour of the current tile (pos>>TILE_LOG2) in the given direction.
- FSM states: IDLE, DECIDE, Q_WANT, Q_CUR, MOVE.
  - IDLE → DECIDE on tick.
  - DECIDE:
    - If want_valid and want==dir^2'b10 (reverse), dir<=want at once with no query. Reversal is legal even when unaligned.
    - Else, if aligned and want_valid and want!=dir → Q_WANT with target(want).
    - Else, if aligned → Q_CUR with target(dir).
    - Else → MOVE.
  - Q_WANT: wall_req=1 with tile held stable until wall_ack.
    - On ack with wall_is_wall=0: dir<=want, then proceed straight to MOVE. The new tile is known open.
    - On ack with wall_is_wall=1: keep dir → Q_CUR.
  - Q_CUR: wall_req=1 until ack.
    - On ack with wall_is_wall=1: moving<=0 → IDLE.
    - On ack with wall_is_wall=0 → MOVE.
  - MOVE: pos += STEP in dir (x for 00/10, y for 01/11), moving<=1 → IDLE.
- wall_req deasserts in the cycle after wall_ack is sampled. An ack while wall_req=0 is ignored.
- Latency: with no query, a tick sampled at clock N updates pos after clock N+2 (visible in cycle N+3). Each query adds (ack latency + 1) cycles.
- Arithmetic: positions are unsigned 10-bit. Tile coordinates are 6-bit. Bounds below are checked before any subtraction.
- Edges, pixel rules:
  - Left at pos_x=0 and right at pos_x=(MAZE_W-1)<<TILE_LOG2 follow the PACMAN_TUNNEL_EN rules.
  - Up and down edges are always walls: no query, treated as wall_is_wall=1.

Optional Feature:
- Macro PACMAN_TUNNEL_EN.
- Defined:
  - Horizontal tile neighbours wrap modulo MAZE_W (left of column 0 is column MAZE_W-1).
  - Moving left from pos_x=0 sets pos_x=(MAZE_W-1)<<TILE_LOG2.
  - Moving right past that value sets pos_x=0.
- Undefined:
  - Horizontal out-of-range neighbours are walls without issuing a query.
  - pos_x never leaves [0, (MAZE_W-1)<<TILE_LOG2].

Test Plan:
1. Reset, then 3 vs falling edges; responder acks after 2 cycles with wall_is_wall=0 → dir=10, pos_x=101, pos_y=184, moving=1. First query tile (12,23).
2. keycode=0x07 at pos_x=101 (unaligned), then a tick → no wall_req; dir=00, pos_x=102 three cycles after vs falls.
3. At aligned (104,184), keycode=0x1A; responder returns wall for (13,22) and open for (12,23) → dir stays 10, pos_x=103, want stays 01.
4. Aligned, dir=00, query returns wall_is_wall=1 → pos unchanged, moving=0, one wall_req/ack pair per frame.
5. PACMAN_TUNNEL_EN defined, pos_x=0, dir=10, query tile (27,y) open → pos_x=216. Undefined → no wall_req, pos_x=0, moving=0.
6. Assert reset while wall_req=1, and send a second vs edge during a 10-cycle ack delay → wall_req=0 next clock, all outputs at reset values; the late ack is ignored and the dropped tick does not move the sprite.
